msg_tx_sequencer: RTL and testbench
===================================

Name: msg_tx_sequencer

Overview:
- Splits a fixed-width ASCII message register into N-bit characters and feeds them, one at a time, to the UART transmitter of the calculator frame.
- Sits directly upstream of the UART TX module. It drives that module's byte and start inputs and watches its busy output.
- Typical use: send the result string or banner once per start request at 9600 baud.

Parameters:
- N, 8, character width in bits; equals the TX data width.
- M, 128, message width in bits; must be a multiple of N, so 16 characters by default.
- SKIP_NUL, 1, when 1, characters equal to 0x00 are skipped rather than sent (Verilog string literals are zero-padded at the MSB end).
- GAP_CYCLES, 0, idle clock cycles inserted after each character completes, before the next one is offered.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, level or pulse; sampled only in IDLE.
- msg, input, M, message; first character is msg[M-1:M-N].
- tx_busy, input, 1, high while the TX module is shifting a byte.
- tx_start, output, 1, one-cycle request to the TX module.
- tx_data, output, N, character presented to TX; held stable from tx_start until tx_busy falls.
- busy, output, 1, high from message capture until done.
- done, output, 1, one-cycle pulse when the last character has finished transmitting.
- char_cnt, output, clog2(M/N+1), number of characters handled so far, counting sent plus skipped.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-message):
  - state=IDLE.
  - tx_start=0, tx_data=0, busy=0, done=0, char_cnt=0.
  - Shift register and gap counter cleared.
- IDLE: busy=0. If start=1 on a rising edge, msg is loaded into the shift register, char_cnt=0, busy=1, next state=CHECK.
- CHECK: head = shift_reg[M-1:M-N].
  - char_cnt==M/N: go to FINISH.
  - SKIP_NUL=1 and head==0: shift left by N, char_cnt+1, stay in CHECK. Costs 1 cycle per skipped character.
  - tx_busy=0: register tx_data=head and tx_start=1 for exactly one cycle; go to WAIT_ACK.
  - tx_busy=1: stay in CHECK; never issue a start while TX is busy.
- WAIT_ACK: tx_start=0. Wait for tx_busy=1, then go to WAIT_DONE. There is no timeout; the TX module must raise busy within a bounded time.
- WAIT_DONE: when tx_busy=0, shift left by N and char_cnt+1.
  - If GAP_CYCLES=0, go to CHECK.
  - Otherwise load the gap counter and go to GAP.
- GAP: decrement the counter; go to CHECK when it reaches 0. Exactly GAP_CYCLES cycles are spent in GAP.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A start in FINISH is ignored. A start held high re-triggers from the first IDLE cycle onward.
- start while busy=1 is ignored; msg changes while busy have no effect because the message is captured at load.
- All-zero msg with SKIP_NUL=1: M/N skip cycles, then done; tx_start never asserted.
- SKIP_NUL=0: all M/N characters are sent, including NULs.
- tx_data changes only on the cycle tx_start is asserted.
- Exactly one tx_start per non-skipped character.

Test Plan:
- Basic send. Setup: M=128, SKIP_NUL=1, msg="Hello". TX model raises busy 1 cycle after tx_start and holds it 10 cycles. Required: tx_data sequence 0x48,0x65,0x6C,0x6C,0x6F, five tx_start pulses, done once, char_cnt=16 at done.
- Reset mid-message. Stimulus: as above, assert reset during the 3rd character. Required: tx_start, busy and char_cnt go to 0 immediately without waiting for a clock; after release, no further tx_start until a new start.
- All-zero message. Stimulus: msg=0, SKIP_NUL=1, start pulse. Required: no tx_start, done pulses exactly 18 cycles after the start edge (load, 16 skips, FINISH).
- SKIP_NUL=0 with msg="AB". Required: 16 tx_start pulses, 14 with 0x00 then 0x41, 0x42.
- Back-pressure and gap. Setup: GAP_CYCLES=4, tx_busy already high when start arrives. Required: first tx_start only after tx_busy falls; between tx_busy falling and the next tx_start there are exactly 5 cycles (1 for WAIT_DONE to CHECK, 4 in GAP).
- Start re-trigger. Stimulus: start pulsed while busy, then start held high. Required: start while busy is ignored; with start held high, the second message begins the cycle after done, and each message yields one done pulse.

Source files
------------

// File: rtl/msg_tx_sequencer.sv
// ============================================================================
// Module   : msg_tx_sequencer
// Brief    : Feeds a fixed-width ASCII message to a UART TX one character at a
//            time, optionally skipping NUL padding characters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module msg_tx_sequencer #(
  parameter int N          = 8,
  parameter int M          = 128,
  parameter int SKIP_NUL   = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [M-1:0]                 msg,
  input  logic                         tx_busy,
  output logic                         tx_start,
  output logic [N-1:0]                 tx_data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(M/N+1)-1:0]     char_cnt
);

  localparam int C_CNT_W = $clog2(M/N+1);
  localparam int C_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST     = C_CNT_W'(M/N);
  localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t             r_state;
  logic [M-1:0]       r_shift;
  logic [C_GAP_W-1:0] r_gap;
  logic [N-1:0]       w_head;
  logic               w_skip;

  assign w_head = r_shift[M-1 -: N];
  assign w_skip = (SKIP_NUL != 0) && (w_head == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_gap    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      char_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift  <= msg;
            char_cnt <= '0;
            busy     <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (char_cnt == C_LAST) begin
            r_state <= S_FINISH;
          end else if (w_skip) begin
            r_shift  <= r_shift << N;
            char_cnt <= char_cnt + 1'b1;
          end else if (!tx_busy) begin
            tx_data  <= w_head;
            tx_start <= 1'b1;
            r_state  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_shift  <= r_shift << N;
            char_cnt <= char_cnt + 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state <= S_CHECK;
            end else begin
              r_gap   <= C_GAP_LOAD;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // Counter is preloaded with GAP_CYCLES-1 so the state lasts GAP_CYCLES cycles
          if (r_gap == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msg_tx_sequencer.sv
// ============================================================================
// Module   : tb_msg_tx_sequencer
// Brief    : Directed self-checking bench for msg_tx_sequencer using three
//            parameterisations driven by a simple busy-for-10-cycles TX model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_msg_tx_sequencer;

  localparam int N  = 8;
  localparam int M  = 128;
  localparam int CW = $clog2(M/N+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [2:0]         start;
  logic [2:0]         bp_hold;
  logic [2:0]         tx_busy;
  logic [2:0]         tx_start;
  logic [2:0]         busy;
  logic [2:0]         done;
  logic [M-1:0]       msg      [3];
  logic [N-1:0]       tx_data  [3];
  logic [CW-1:0]      char_cnt [3];

  int                 bcnt     [3] = '{0, 0, 0};
  int                 n_start  [3] = '{0, 0, 0};
  int                 n_done   [3] = '{0, 0, 0};
  logic [N-1:0]       sent     [3][0:63];

  int n_checks = 0;
  int n_pass   = 0;

  // 0: SKIP_NUL=1 GAP=0, 1: SKIP_NUL=0 GAP=0, 2: SKIP_NUL=1 GAP=4
  msg_tx_sequencer #(.N(N), .M(M), .SKIP_NUL(1), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .msg(msg[0]), .tx_busy(tx_busy[0]),
    .tx_start(tx_start[0]), .tx_data(tx_data[0]), .busy(busy[0]), .done(done[0]),
    .char_cnt(char_cnt[0]));

  msg_tx_sequencer #(.N(N), .M(M), .SKIP_NUL(0), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .msg(msg[1]), .tx_busy(tx_busy[1]),
    .tx_start(tx_start[1]), .tx_data(tx_data[1]), .busy(busy[1]), .done(done[1]),
    .char_cnt(char_cnt[1]));

  msg_tx_sequencer #(.N(N), .M(M), .SKIP_NUL(1), .GAP_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .msg(msg[2]), .tx_busy(tx_busy[2]),
    .tx_start(tx_start[2]), .tx_data(tx_data[2]), .busy(busy[2]), .done(done[2]),
    .char_cnt(char_cnt[2]));

  // TX model: busy rises one cycle after tx_start and stays high for 10 cycles
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset)            bcnt[i] <= 0;
      else if (tx_start[i]) bcnt[i] <= 10;
      else if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  assign tx_busy[0] = (bcnt[0] != 0) | bp_hold[0];
  assign tx_busy[1] = (bcnt[1] != 0) | bp_hold[1];
  assign tx_busy[2] = (bcnt[2] != 0) | bp_hold[2];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tx_start[i]) begin
        if (n_start[i] < 64) sent[i][n_start[i]] <= tx_data[i];
        n_start[i] <= n_start[i] + 1;
      end
      if (done[i]) n_done[i] <= n_done[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Returns at the negedge on which done is observed high
  task automatic wait_done(input int i, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done[i]) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [5];
    int b0, d0, b1, k, lat, t0, t1, zeros, phase;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    reset   = 1'b1;
    start   = '0;
    bp_hold = '0;
    msg[0]  = '0;
    msg[1]  = '0;
    msg[2]  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start[0]), 32'd0);
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_done",     32'(done[0]),     32'd0);
    check("rst_char_cnt", 32'(char_cnt[0]), 32'd0);
    check("rst_tx_data",  32'(tx_data[0]),  32'd0);
    reset = 1'b0;

    // Basic send: 11 leading NULs are skipped, then "Hello"
    msg[0] = "Hello";
    b0 = n_start[0];
    d0 = n_done[0];
    pulse_start(0);
    wait_done(0, 400, "t1_done_seen");
    check("t1_cnt_at_done",  32'(char_cnt[0]), 32'd16);
    check("t1_busy_at_done", 32'(busy[0]),     32'd0);
    @(negedge clk);
    check("t1_nstart", 32'(n_start[0] - b0), 32'd5);
    for (int j = 0; j < 5; j++) check("t1_byte", 32'(sent[0][b0+j]), 32'(hello[j]));
    repeat (5) @(negedge clk);
    check("t1_ndone", 32'(n_done[0] - d0), 32'd1);

    // Reset while the third character is being requested
    pulse_start(0);
    k = 0;
    for (int c = 0; c < 600 && k < 3; c++) begin
      @(negedge clk);
      if (tx_start[0]) k++;
    end
    check("t2_third_start", 32'(k), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t2_async_tx_start", 32'(tx_start[0]), 32'd0);
    check("t2_async_busy",     32'(busy[0]),     32'd0);
    check("t2_async_char_cnt", 32'(char_cnt[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    b1 = n_start[0];
    repeat (40) @(negedge clk);
    check("t2_no_restart", 32'(n_start[0] - b1), 32'd0);
    check("t2_idle_busy",  32'(busy[0]),         32'd0);

    // All-zero message: done 18 cycles after the start edge
    msg[0] = '0;
    b0 = n_start[0];
    d0 = n_done[0];
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start[0] = 1'b0;
      if (done[0]) lat = c;
    end
    check("t3_done_latency", 32'(lat), 32'd18);
    repeat (3) @(negedge clk);
    check("t3_no_tx_start", 32'(n_start[0] - b0), 32'd0);
    check("t3_ndone",       32'(n_done[0] - d0),  32'd1);

    // SKIP_NUL=0: fourteen NULs then 'A','B'
    msg[1] = "AB";
    b0 = n_start[1];
    pulse_start(1);
    wait_done(1, 600, "t4_done_seen");
    check("t4_cnt_at_done", 32'(char_cnt[1]), 32'd16);
    @(negedge clk);
    check("t4_nstart", 32'(n_start[1] - b0), 32'd16);
    zeros = 0;
    for (int j = 0; j < 14; j++) if (sent[1][b0+j] == 8'h00) zeros++;
    check("t4_nul_count", 32'(zeros), 32'd14);
    check("t4_byte_a", 32'(sent[1][b0+14]), 32'h41);
    check("t4_byte_b", 32'(sent[1][b0+15]), 32'h42);

    // Back-pressure and inter-character gap
    msg[2] = "AB";
    @(negedge clk);
    bp_hold[2] = 1'b1;
    b0 = n_start[2];
    pulse_start(2);
    repeat (20) @(negedge clk);
    check("t5_held_off",  32'(n_start[2] - b0), 32'd0);
    check("t5_busy_held", 32'(busy[2]),         32'd1);
    bp_hold[2] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (tx_start[2]) lat = c;
    end
    check("t5_first_start_lat", 32'(lat), 32'd1);
    phase = 0;
    t0 = -1;
    t1 = -1;
    for (int c = 1; c <= 100 && t1 < 0; c++) begin
      @(negedge clk);
      if (phase == 0 && tx_busy[2]) phase = 1;
      else if (phase == 1 && !tx_busy[2]) begin t0 = c; phase = 2; end
      else if (phase == 2 && tx_start[2]) t1 = c;
    end
    // Cycles strictly between the first low-busy cycle and the tx_start cycle
    check("t5_gap_between", 32'(t1 - t0 - 1), 32'd5);
    wait_done(2, 200, "t5_done_seen");
    @(negedge clk);
    check("t5_nstart", 32'(n_start[2] - b0), 32'd2);
    check("t5_byte_a", 32'(sent[2][b0]),     32'h41);
    check("t5_byte_b", 32'(sent[2][b0+1]),   32'h42);

    // Start while busy is ignored; held start re-triggers right after done
    msg[0] = "Hello";
    b0 = n_start[0];
    d0 = n_done[0];
    pulse_start(0);
    repeat (5) @(negedge clk);
    pulse_start(0);
    wait_done(0, 400, "t6_first_done");
    start[0] = 1'b1;
    check("t6_busy_at_done", 32'(busy[0]), 32'd0);
    @(negedge clk);
    check("t6_restart_busy", 32'(busy[0]), 32'd1);
    msg[0] = "XY";
    wait_done(0, 400, "t6_second_done");
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_nstart",    32'(n_start[0] - b0),   32'd10);
    check("t6_ndone",     32'(n_done[0] - d0),    32'd2);
    check("t6_last_byte", 32'(sent[0][b0+9]),     32'h6F);
    check("t6_idle_busy", 32'(busy[0]),           32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
